// File: rtl/mac_tx_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-stream TX port between N sources,
// with a 2-entry output slice (output register + skid register) towards the MAC.
//   state | meaning
//   IDLE  | no owner; pick the next requesting source unless paused
//   BUSY  | owner streams until its last beat is accepted
module mac_tx_stream_arbiter #(
  parameter int N      = 2,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N*DATA_W-1:0]   s_data,
  input  logic [N-1:0]          s_valid,
  input  logic [N-1:0]          s_last,
  output logic [N-1:0]          s_ready,
  output logic [DATA_W-1:0]     m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  input  logic                  pause,
  output logic [N-1:0]          grant,
  output logic                  busy,
  output logic [15:0]           frame_count
);

  localparam int PTR_W = $clog2(N);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} stateT;

  stateT              state, stateNext;
  logic [N-1:0]       grantQ, grantNext;
  logic [PTR_W-1:0]   rrPtr, rrPtrNext;
  logic               found;
  int                 cand;

  logic               outValid, outLast, skidValid, skidLast;
  logic [DATA_W-1:0]  outData, skidData, srcData;
  logic               srcLast, accept;
  logic [15:0]        frameCnt;

  // rrPtr always holds the current owner while BUSY, so it doubles as the data mux select
  assign srcData = s_data[int'(rrPtr)*DATA_W +: DATA_W];
  assign srcLast = s_last[rrPtr];
  assign s_ready = (state == BUSY && !skidValid) ? grantQ : '0;
  assign accept  = |(s_valid & s_ready);

  always_comb begin
    stateNext = state;
    grantNext = grantQ;
    rrPtrNext = rrPtr;
    found     = 1'b0;
    cand      = 0;
    case (state)
      IDLE: begin
        if (!pause) begin
          for (int k = 1; k <= N; k++) begin
            cand = int'(rrPtr) + k;
            if (cand >= N) cand = cand - N;
            if (!found && s_valid[cand]) begin
              found           = 1'b1;
              rrPtrNext       = PTR_W'(cand);
              grantNext       = '0;
              grantNext[cand] = 1'b1;
            end
          end
        end
        if (found) stateNext = BUSY;
      end
      BUSY: begin
        if (accept && srcLast) begin
          stateNext = IDLE;
          grantNext = '0;
        end
      end
      default: begin
        stateNext = IDLE;
        grantNext = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      grantQ <= '0;
      rrPtr  <= PTR_W'(N - 1);
    end else begin
      state  <= stateNext;
      grantQ <= grantNext;
      rrPtr  <= rrPtrNext;
    end
  end

  // Skid register only fills when a beat is accepted while the output register is stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outValid  <= 1'b0;
      outData   <= '0;
      outLast   <= 1'b0;
      skidValid <= 1'b0;
      skidData  <= '0;
      skidLast  <= 1'b0;
    end else if (!outValid || m_ready) begin
      if (skidValid) begin
        outValid  <= 1'b1;
        outData   <= skidData;
        outLast   <= skidLast;
        skidValid <= 1'b0;
      end else if (accept) begin
        outValid <= 1'b1;
        outData  <= srcData;
        outLast  <= srcLast;
      end else begin
        outValid <= 1'b0;
      end
    end else if (accept) begin
      skidValid <= 1'b1;
      skidData  <= srcData;
      skidLast  <= srcLast;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frameCnt <= '0;
    end else if (outValid && m_ready && outLast) begin
      frameCnt <= frameCnt + 16'd1;
    end
  end

  assign m_valid     = outValid;
  assign m_data      = outData;
  assign m_last      = outLast;
  assign grant       = grantQ;
  assign busy        = (state == BUSY);
  assign frame_count = frameCnt;

endmodule
